// File: rtl/tlrot_host_arb.sv
// Two-host TL-UL arbiter in front of the RoT register port: round-robin A channel,
// D channel steered back by a host tag carried in a_source[7].

module tlrot_host_arb_cnt #(
    parameter int MaxOutstanding = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       inc,
    input  logic       dec,
    output logic [3:0] cnt,
    output logic       room
);
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= 4'd0;
        end else if (inc && !dec) begin
            if (cnt != 4'hf) cnt <= cnt + 4'd1;
        end else if (dec && !inc) begin
            // A stray response to an idle host is forwarded but must not wrap the count.
            if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
    end

    assign room = (cnt < 4'(MaxOutstanding));
endmodule

module tlrot_host_arb #(
    parameter int MaxOutstanding = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        init_done_i,
    input  logic        h0_a_valid,
    output logic        h0_a_ready,
    input  logic [83:0] h0_a_bits,
    output logic        h0_d_valid,
    input  logic        h0_d_ready,
    output logic [49:0] h0_d_bits,
    input  logic        h1_a_valid,
    output logic        h1_a_ready,
    input  logic [83:0] h1_a_bits,
    output logic        h1_d_valid,
    input  logic        h1_d_ready,
    output logic [49:0] h1_d_bits,
    output logic        dn_a_valid,
    input  logic        dn_a_ready,
    output logic [83:0] dn_a_bits,
    input  logic        dn_d_valid,
    output logic        dn_d_ready,
    input  logic [49:0] dn_d_bits,
    output logic [3:0]  h0_outstanding_o,
    output logic [3:0]  h1_outstanding_o,
    output logic        src_err_o,
    output logic        idle_o
);
    localparam int ASrcTag = 75;
    localparam int DSrcTag = 41;

    localparam logic [1:0] WaitInit = 2'd0;
    localparam logic [1:0] Idle     = 2'd1;
    localparam logic [1:0] Locked   = 2'd2;

    logic [1:0]       state;
    logic             gnt;
    logic             last;
    logic             src_err;
    logic             locked;
    logic             gnt_nxt;
    logic             d_tag;
    logic [49:0]      d_bits;
    logic [1:0]       a_valid;
    logic [1:0]       elig;
    logic [1:0]       room;
    logic [1:0]       a_hs;
    logic [1:0]       d_hs;
    logic [1:0][3:0]  cnt;
    logic [1:0][83:0] a_bits;

    assign a_valid = {h1_a_valid, h0_a_valid};
    assign a_bits  = {h1_a_bits, h0_a_bits};
    assign locked  = (state == Locked);

    assign elig    = a_valid & room & {2{init_done_i}};
    assign gnt_nxt = (elig == 2'b11) ? ~last : elig[1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= WaitInit;
            gnt     <= 1'b0;
            last    <= 1'b1;
            src_err <= 1'b0;
        end else begin
            case (state)
                WaitInit: if (init_done_i) state <= Idle;
                Idle: begin
                    if (|elig) begin
                        gnt   <= gnt_nxt;
                        state <= Locked;
                    end
                end
                Locked: begin
                    // Held until the RoT accepts, regardless of init_done_i.
                    if (dn_a_ready) begin
                        last    <= gnt;
                        src_err <= src_err | a_bits[gnt][ASrcTag];
                        state   <= Idle;
                    end
                end
                default: state <= WaitInit;
            endcase
        end
    end

    always_comb begin
        dn_a_bits          = a_bits[gnt];
        dn_a_bits[ASrcTag] = gnt;
    end

    assign dn_a_valid = locked;
    assign a_hs[0]    = locked & dn_a_ready & ~gnt;
    assign a_hs[1]    = locked & dn_a_ready & gnt;
    assign h0_a_ready = a_hs[0];
    assign h1_a_ready = a_hs[1];

    always_comb begin
        d_bits          = dn_d_bits;
        d_bits[DSrcTag] = 1'b0;
    end

    assign d_tag      = dn_d_bits[DSrcTag];
    assign h0_d_valid = dn_d_valid & ~d_tag;
    assign h1_d_valid = dn_d_valid & d_tag;
    assign h0_d_bits  = d_bits;
    assign h1_d_bits  = d_bits;
    assign dn_d_ready = d_tag ? h1_d_ready : h0_d_ready;
    assign d_hs[0]    = h0_d_valid & h0_d_ready;
    assign d_hs[1]    = h1_d_valid & h1_d_ready;

    for (genvar h = 0; h < 2; h++) begin : g_host
        tlrot_host_arb_cnt #(.MaxOutstanding(MaxOutstanding)) u_cnt (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .inc    (a_hs[h]),
            .dec    (d_hs[h]),
            .cnt    (cnt[h]),
            .room   (room[h])
        );
    end

    assign h0_outstanding_o = cnt[0];
    assign h1_outstanding_o = cnt[1];
    assign src_err_o        = src_err;
    assign idle_o           = (state == Idle) & ~|a_valid & (cnt[0] == 4'd0) & (cnt[1] == 4'd0);
endmodule

// File: tb/tb_tlrot_host_arb.sv
// Directed bench for tlrot_host_arb: init gating, round-robin, D routing,
// outstanding limits, A stall stability, source-tag error and async reset.

module tb_tlrot_host_arb;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        init_done_i;
    logic        h0_a_valid, h0_a_ready, h0_d_valid, h0_d_ready;
    logic        h1_a_valid, h1_a_ready, h1_d_valid, h1_d_ready;
    logic [83:0] h0_a_bits, h1_a_bits, dn_a_bits;
    logic [49:0] h0_d_bits, h1_d_bits, dn_d_bits;
    logic        dn_a_valid, dn_a_ready, dn_d_valid, dn_d_ready;
    logic [3:0]  h0_outstanding_o, h1_outstanding_o;
    logic        src_err_o, idle_o;

    int nvec = 0;
    int nerr = 0;

    always #5 clk_i = ~clk_i;

    tlrot_host_arb #(.MaxOutstanding(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .init_done_i(init_done_i),
        .h0_a_valid(h0_a_valid), .h0_a_ready(h0_a_ready), .h0_a_bits(h0_a_bits),
        .h0_d_valid(h0_d_valid), .h0_d_ready(h0_d_ready), .h0_d_bits(h0_d_bits),
        .h1_a_valid(h1_a_valid), .h1_a_ready(h1_a_ready), .h1_a_bits(h1_a_bits),
        .h1_d_valid(h1_d_valid), .h1_d_ready(h1_d_ready), .h1_d_bits(h1_d_bits),
        .dn_a_valid(dn_a_valid), .dn_a_ready(dn_a_ready), .dn_a_bits(dn_a_bits),
        .dn_d_valid(dn_d_valid), .dn_d_ready(dn_d_ready), .dn_d_bits(dn_d_bits),
        .h0_outstanding_o(h0_outstanding_o), .h1_outstanding_o(h1_outstanding_o),
        .src_err_o(src_err_o), .idle_o(idle_o)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Get request: {opcode=4,param=0,size=2,source,address,mask=f,data=0}
    function automatic logic [83:0] mk_a(input logic [7:0] src, input logic [31:0] addr);
        return {3'd4, 3'd0, 2'd2, src, addr, 4'hf, 32'h0};
    endfunction

    // AccessAckData: {opcode=1,param=0,size=2,source,sink=0,data,denied=0}
    function automatic logic [49:0] mk_d(input logic [7:0] src, input logic [31:0] data);
        return {3'd1, 3'd0, 2'd2, src, 1'b0, data, 1'b0};
    endfunction

    task automatic clear_inputs();
        h0_a_valid = 1'b0; h0_a_bits = '0; h0_d_ready = 1'b1;
        h1_a_valid = 1'b0; h1_a_bits = '0; h1_d_ready = 1'b1;
        dn_a_ready = 1'b0; dn_d_valid = 1'b0; dn_d_bits = '0;
    endtask

    // Returns on the negedge where reset is released; init_done_i is left high.
    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        clear_inputs();
        init_done_i = 1'b1;
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        rst_ni = 1'b0;
        init_done_i = 1'b0;
        clear_inputs();
        #12;
        chk("rst dn_a_valid", dn_a_valid, 1'b0);
        chk("rst h0_a_ready", h0_a_ready, 1'b0);
        chk("rst h1_a_ready", h1_a_ready, 1'b0);
        chk("rst h0_cnt", h0_outstanding_o, 4'd0);
        chk("rst h1_cnt", h1_outstanding_o, 4'd0);
        chk("rst src_err", src_err_o, 1'b0);
        chk("rst idle", idle_o, 1'b0);

        // Init gating
        @(negedge clk_i);
        rst_ni = 1'b1;
        h0_a_valid = 1'b1; h0_a_bits = mk_a(8'h05, 32'h100); dn_a_ready = 1'b1;
        repeat (10) begin
            @(negedge clk_i);
            chk("t1 no grant valid", dn_a_valid, 1'b0);
            chk("t1 no grant ready", h0_a_ready, 1'b0);
        end
        init_done_i = 1'b1;
        @(negedge clk_i);
        chk("t1 +1 cycle", dn_a_valid, 1'b0);
        @(negedge clk_i);
        chk("t1 +2 valid", dn_a_valid, 1'b1);
        chk("t1 +2 ready", h0_a_ready, 1'b1);
        chk("t1 bits", dn_a_bits, mk_a(8'h05, 32'h100));
        @(negedge clk_i);
        h0_a_valid = 1'b0;
        chk("t1 h0_cnt", h0_outstanding_o, 4'd1);
        chk("t1 idle after", dn_a_valid, 1'b0);

        // D routing by tag
        dn_d_valid = 1'b1; dn_d_bits = mk_d(8'h85, 32'hDEADBEEF);
        #1;
        chk("t3 h1_d_valid", h1_d_valid, 1'b1);
        chk("t3 h0_d_valid", h0_d_valid, 1'b0);
        chk("t3 h1_d_bits", h1_d_bits, mk_d(8'h05, 32'hDEADBEEF));
        chk("t3 dn_d_ready", dn_d_ready, 1'b1);
        @(negedge clk_i);
        chk("t3 h1_cnt held 0", h1_outstanding_o, 4'd0);
        dn_d_bits = mk_d(8'h05, 32'hDEADBEEF);
        #1;
        chk("t3 h0_d_valid", h0_d_valid, 1'b1);
        chk("t3 h1_d_valid off", h1_d_valid, 1'b0);
        chk("t3 h0_d_bits", h0_d_bits, mk_d(8'h05, 32'hDEADBEEF));
        @(negedge clk_i);
        dn_d_valid = 1'b0;
        chk("t3 h0_cnt", h0_outstanding_o, 4'd0);
        #1;
        chk("t3 idle", idle_o, 1'b1);

        // Round-robin from reset: h0 first
        do_reset();
        h0_a_valid = 1'b1; h0_a_bits = mk_a(8'h01, 32'h10);
        h1_a_valid = 1'b1; h1_a_bits = mk_a(8'h02, 32'h20);
        dn_a_ready = 1'b1;
        @(negedge clk_i);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("t2 valid", dn_a_valid, 1'b1);
            chk("t2 tag", dn_a_bits[75], i[0]);
            chk("t2 bits", dn_a_bits, i[0] ? mk_a(8'h82, 32'h20) : mk_a(8'h01, 32'h10));
            @(negedge clk_i);
            chk("t2 gap", dn_a_valid, 1'b0);
        end
        h0_a_valid = 1'b0; h1_a_valid = 1'b0;
        chk("t2 h0_cnt", h0_outstanding_o, 4'd2);
        chk("t2 h1_cnt", h1_outstanding_o, 4'd2);

        // Outstanding limit
        do_reset();
        h0_a_valid = 1'b1; h0_a_bits = mk_a(8'h05, 32'h200); dn_a_ready = 1'b1;
        @(negedge clk_i);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("t4 grant", dn_a_valid, 1'b1);
            @(negedge clk_i);
        end
        chk("t4 h0_cnt max", h0_outstanding_o, 4'd4);
        @(negedge clk_i);
        chk("t4 held valid", dn_a_valid, 1'b0);
        chk("t4 held ready", h0_a_ready, 1'b0);
        h1_a_valid = 1'b1; h1_a_bits = mk_a(8'h03, 32'h300);
        @(negedge clk_i);
        chk("t4 h1 granted", dn_a_bits, mk_a(8'h83, 32'h300));
        chk("t4 h0 still held", h0_a_ready, 1'b0);
        @(negedge clk_i);
        h1_a_valid = 1'b0;
        chk("t4 h1_cnt", h1_outstanding_o, 4'd1);
        dn_d_valid = 1'b1; dn_d_bits = mk_d(8'h05, 32'h0);
        #1;
        chk("t4 d to h0", h0_d_valid, 1'b1);
        @(negedge clk_i);
        dn_d_valid = 1'b0;
        chk("t4 h0_cnt after d", h0_outstanding_o, 4'd3);
        chk("t4 no grant same edge", dn_a_valid, 1'b0);
        @(negedge clk_i);
        chk("t4 5th granted", dn_a_valid, 1'b1);
        chk("t4 5th bits", dn_a_bits, mk_a(8'h05, 32'h200));
        @(negedge clk_i);
        h0_a_valid = 1'b0;
        chk("t4 h0_cnt refilled", h0_outstanding_o, 4'd4);

        // Stall stability, then same-cycle A+D
        do_reset();
        h1_a_valid = 1'b1; h1_a_bits = mk_a(8'h07, 32'h400);
        @(negedge clk_i);
        @(negedge clk_i);
        h0_a_valid = 1'b1; h0_a_bits = mk_a(8'h01, 32'h500);
        chk("t5 h1 locked", dn_a_bits, mk_a(8'h87, 32'h400));
        repeat (5) begin
            @(negedge clk_i);
            chk("t5 stall valid", dn_a_valid, 1'b1);
            chk("t5 stall bits", dn_a_bits, mk_a(8'h87, 32'h400));
            chk("t5 stall ready", h1_a_ready, 1'b0);
        end
        dn_a_ready = 1'b1;
        #1;
        chk("t5 h1_a_ready", h1_a_ready, 1'b1);
        chk("t5 h0_a_ready", h0_a_ready, 1'b0);
        @(negedge clk_i);
        h1_a_valid = 1'b0;
        chk("t5 h1_cnt", h1_outstanding_o, 4'd1);
        chk("t5 h0_cnt", h0_outstanding_o, 4'd0);
        @(negedge clk_i);
        chk("t5 h0 granted", dn_a_bits, mk_a(8'h01, 32'h500));
        dn_d_valid = 1'b1; dn_d_bits = mk_d(8'h05, 32'h1234);
        @(negedge clk_i);
        dn_d_valid = 1'b0; h0_a_valid = 1'b0;
        chk("t5 a+d cnt", h0_outstanding_o, 4'd0);
        chk("t5 h1_cnt kept", h1_outstanding_o, 4'd1);

        // Source tag error, then async reset while locked
        h0_a_valid = 1'b1; h0_a_bits = mk_a(8'h80, 32'h600);
        @(negedge clk_i);
        chk("t6 tag overwritten", dn_a_bits, mk_a(8'h00, 32'h600));
        chk("t6 src_err before", src_err_o, 1'b0);
        @(negedge clk_i);
        chk("t6 src_err after", src_err_o, 1'b1);
        h0_a_bits = mk_a(8'h06, 32'h700);
        @(negedge clk_i);
        chk("t6 locked again", dn_a_valid, 1'b1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("t6 async dn_a_valid", dn_a_valid, 1'b0);
        chk("t6 async h0_a_ready", h0_a_ready, 1'b0);
        chk("t6 async src_err", src_err_o, 1'b0);
        chk("t6 async h0_cnt", h0_outstanding_o, 4'd0);
        chk("t6 async h1_cnt", h1_outstanding_o, 4'd0);
        chk("t6 async idle", idle_o, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
